// File: rtl/pem_ref_generator_pkg.sv
// Shared types and widths for the PEM reference generator.
// The accumulator carries one extra bit so acc+inc cannot overflow before the modulus compare.
package pem_ref_generator_pkg;

  localparam int ACC_W  = 21;
  localparam int FREQ_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_RUN    = 2'd2
  } pem_state_e;

  // A frequency is usable only if it is nonzero and strictly below the window length.
  function automatic logic freq_load_ok(input logic [FREQ_W-1:0] freq,
                                        input logic [FREQ_W-1:0] modulus);
    return (freq != '0) && (freq < modulus);
  endfunction

endpackage

// File: rtl/pem_phase_accumulator.sv
// Combinational modular step for the phase accumulator: next = (acc + inc) mod MODULUS.
// o_wrap marks the step that crossed the modulus, i.e. one synthesized reference edge.
module pem_phase_accumulator
  import pem_ref_generator_pkg::*;
#(
  parameter logic [FREQ_W-1:0] MODULUS = 20'd1000000
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [FREQ_W-1:0] i_inc,
  output logic [ACC_W-1:0]  o_acc_next,
  output logic              o_wrap
);

  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_modulus;

  assign w_modulus  = {{(ACC_W-FREQ_W){1'b0}}, MODULUS};
  assign w_sum      = i_acc + {{(ACC_W-FREQ_W){1'b0}}, i_inc};
  assign o_wrap     = (w_sum >= w_modulus);
  assign o_acc_next = o_wrap ? (w_sum - w_modulus) : w_sum;

endmodule

// File: rtl/pem_ref_generator.sv
// Synthesizes a reference edge strobe at frequency/frequency_detect_count edges per sample
// using a drift-free modular phase accumulator, with optional divide-by-2 output filtering.
//
// state     | meaning
// ST_IDLE   | waiting for an accepted frequency load; accumulator held at 0
// ST_LOADED | increment valid, waiting for first data_valid to start
// ST_RUN    | one accumulator step per data_valid, PEM_posedge on wrap
module pem_ref_generator
  import pem_ref_generator_pkg::*;
#(
  parameter logic [FREQ_W-1:0] frequency_detect_count = 20'd1000000,
  parameter logic [FREQ_W-1:0] filter_threshold       = 20'd75000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              data_valid,
  input  logic [FREQ_W-1:0] frequency,
  input  logic              frequency_valid,
  output logic              PEM_posedge,
  output logic              PEM_posedge_filtered,
  output logic              filter_sig,
  output logic [FREQ_W-1:0] phase,
  output logic              running,
  output logic              freq_error
);

  pem_state_e        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [FREQ_W-1:0] r_inc;
  logic              r_pulse;
  logic              r_toggle;
  logic              r_filter_sig;
  logic              r_freq_error;

  logic              w_load_ok;
  logic              w_step;
  logic              w_wrap;
  logic [ACC_W-1:0]  w_acc_next;

  assign w_load_ok = freq_load_ok(frequency, frequency_detect_count);
  assign w_step    = enable && data_valid && (r_state != ST_IDLE);

  pem_phase_accumulator #(
    .MODULUS (frequency_detect_count)
  ) u_phase_acc (
    .i_acc      (r_acc),
    .i_inc      (r_inc),
    .o_acc_next (w_acc_next),
    .o_wrap     (w_wrap)
  );

  // The step always uses the registered increment, so a coincident load takes effect one step later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_pulse  <= 1'b0;
      r_toggle <= 1'b0;
    end else if (!enable) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_pulse  <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_pulse <= w_step && w_wrap;
      if (w_step) begin
        r_acc   <= w_acc_next;
        r_state <= ST_RUN;
      end else if ((r_state == ST_IDLE) && frequency_valid && w_load_ok) begin
        r_state <= ST_LOADED;
      end
      if (r_pulse && r_filter_sig) begin
        r_toggle <= ~r_toggle;
      end
    end
  end

  // Increment and filter selection survive IDLE so a rejected load leaves the last good setting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc        <= '0;
      r_filter_sig <= 1'b0;
      r_freq_error <= 1'b0;
    end else if (frequency_valid) begin
      if (w_load_ok) begin
        r_inc        <= frequency;
        r_filter_sig <= (frequency > filter_threshold);
        r_freq_error <= 1'b0;
      end else begin
        r_freq_error <= 1'b1;
      end
    end
  end

  assign PEM_posedge          = r_pulse;
  assign PEM_posedge_filtered = r_pulse && !(r_filter_sig && r_toggle);
  assign filter_sig           = r_filter_sig;
  assign phase                = r_acc[FREQ_W-1:0];
  assign running              = (r_state == ST_RUN);
  assign freq_error           = r_freq_error;

endmodule
